// File: rtl/nvio3_pkg.sv
// Shared link-register definitions: register count, data width and the write record.
package nvio3_pkg;
    localparam int LK_REGS  = 8;
    localparam int LK_WIDTH = 128;
    localparam int LK_RW    = $clog2(LK_REGS);

    typedef struct packed {
        logic [LK_RW-1:0]    lreg;
        logic [LK_WIDTH-1:0] dat;
    } lk_wr_t;
endpackage

// File: rtl/lk_cq_mem.sv
// Commit-queue storage: DEPTH x lk_wr_t, two write ports at posedge, two combinational reads.
// Contents are not reset; validity is tracked by the parent's count.
module lk_cq_mem
    import nvio3_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we0,
    input  logic [$clog2(DEPTH)-1:0] wadr0,
    input  lk_wr_t                   wdat0,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] wadr1,
    input  lk_wr_t                   wdat1,
    input  logic [$clog2(DEPTH)-1:0] radr0,
    input  logic [$clog2(DEPTH)-1:0] radr1,
    output lk_wr_t                   rdat0,
    output lk_wr_t                   rdat1
);
    lk_wr_t mem_q [DEPTH];

    // The parent never targets the same address with both ports in one cycle.
    always_ff @(posedge clk) begin
        if (we0) mem_q[wadr0] <= wdat0;
        if (we1) mem_q[wadr1] <= wdat1;
    end

    assign rdat0 = mem_q[radr0];
    assign rdat1 = mem_q[radr1];
endmodule

// File: rtl/lk_commit_queue.sv
// Link-register commit queue: accepts a commit pair when two entries are free, drains the oldest two
// one edge after acceptance (same-register pairs coalesce into port 1); hold stalls draining.
module lk_commit_queue
    import nvio3_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid0,
    input  logic [2:0]                 in_reg0,
    input  logic [127:0]               in_dat0,
    input  logic                       in_valid1,
    input  logic [2:0]                 in_reg1,
    input  logic [127:0]               in_dat1,
    output logic                       in_ready,
    input  logic                       hold,
    output logic                       wr0,
    output logic [2:0]                 wa0,
    output logic [127:0]               i0,
    output logic                       wr1,
    output logic [2:0]                 wa1,
    output logic [127:0]               i1,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          accept, keep0, keep1;
    logic          we0, we1;
    logic [AW-1:0] wadr0, wadr1;
    lk_wr_t        wdat0, wdat1, h0, h1;
    logic [1:0]    enq, deq;

    // Readiness looks only at registered occupancy, never at this cycle's drain.
    assign in_ready = (count_q <= CW'(DEPTH - 2));
    assign accept   = in_ready && in_valid0;

    always_comb begin
        keep0 = accept && (in_reg0 != 3'd0);
        keep1 = accept && in_valid1 && (in_reg1 != 3'd0);
        we0   = keep0 || keep1;
        wadr0 = wr_ptr_q;
        wdat0 = keep0 ? lk_wr_t'{lreg: in_reg0, dat: in_dat0}
                      : lk_wr_t'{lreg: in_reg1, dat: in_dat1};
        we1   = keep0 && keep1;
        wadr1 = wr_ptr_q + AW'(1);
        wdat1 = lk_wr_t'{lreg: in_reg1, dat: in_dat1};
        enq   = {1'b0, keep0} + {1'b0, keep1};
    end

    lk_cq_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we0   (we0),
        .wadr0 (wadr0),
        .wdat0 (wdat0),
        .we1   (we1),
        .wadr1 (wadr1),
        .wdat1 (wdat1),
        .radr0 (rd_ptr_q),
        .radr1 (rd_ptr_q + AW'(1)),
        .rdat0 (h0),
        .rdat1 (h1)
    );

    always_comb begin
        wr0 = 1'b0;
        wr1 = 1'b0;
        wa0 = h0.lreg;
        i0  = h0.dat;
        wa1 = h1.lreg;
        i1  = h1.dat;
        deq = 2'd0;
        if (!hold && count_q == CW'(1)) begin
            wr0 = 1'b1;
            deq = 2'd1;
        end else if (!hold && count_q >= CW'(2)) begin
            // The younger write wins when both target the same register.
            wr0 = (h0.lreg != h1.lreg);
            wr1 = 1'b1;
            deq = 2'd2;
        end
    end

    always_comb begin
        count_d  = count_q + CW'(enq) - CW'(deq);
        wr_ptr_d = wr_ptr_q + AW'(enq);
        rd_ptr_d = rd_ptr_q + AW'(deq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
endmodule

// File: tb/tb_lk_commit_queue.sv
// Directed bench for lk_commit_queue with a reference queue model of accepted writes.
module tb_lk_commit_queue;
    import nvio3_pkg::*;

    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid0, in_valid1, hold;
    logic [2:0]   in_reg0, in_reg1;
    logic [127:0] in_dat0, in_dat1;
    logic         in_ready, wr0, wr1, empty, full;
    logic [2:0]   wa0, wa1;
    logic [127:0] i0, i1;
    logic [3:0]   count;

    int checks   = 0;
    int failures = 0;
    lk_wr_t mq[$];

    lk_commit_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid0 (in_valid0),
        .in_reg0   (in_reg0),
        .in_dat0   (in_dat0),
        .in_valid1 (in_valid1),
        .in_reg1   (in_reg1),
        .in_dat1   (in_dat1),
        .in_ready  (in_ready),
        .hold      (hold),
        .wr0       (wr0),
        .wa0       (wa0),
        .i0        (i0),
        .wr1       (wr1),
        .wa1       (wa1),
        .i1        (i1),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One cycle: drive inputs, check outputs against the model, then advance the model at the edge.
    task automatic cyc(input logic v0, input logic [2:0] r0, input logic [127:0] d0,
                       input logic v1, input logic [2:0] r1, input logic [127:0] d1,
                       input logic h);
        int n;
        bit rdy;
        int ndeq;
        in_valid0 = v0; in_reg0 = r0; in_dat0 = d0;
        in_valid1 = v1; in_reg1 = r1; in_dat1 = d1;
        hold = h;
        @(negedge clk);
        n    = mq.size();
        rdy  = (DEPTH - n) >= 2;
        ndeq = 0;
        chk("count", 128'(count), 128'(n));
        chk("empty", 128'(empty), 128'(n == 0));
        chk("full", 128'(full), 128'(n == DEPTH));
        chk("in_ready", 128'(in_ready), 128'(rdy));
        if (h || n == 0) begin
            chk("wr0_idle", 128'(wr0), 128'(0));
            chk("wr1_idle", 128'(wr1), 128'(0));
        end else if (n == 1) begin
            ndeq = 1;
            chk("wr0_single", 128'(wr0), 128'(1));
            chk("wr1_single", 128'(wr1), 128'(0));
            if (wr0) begin
                chk("wa0", 128'(wa0), 128'(mq[0].lreg));
                chk("i0", i0, mq[0].dat);
            end
        end else begin
            ndeq = 2;
            chk("wr0_pair", 128'(wr0), 128'(mq[0].lreg != mq[1].lreg));
            chk("wr1_pair", 128'(wr1), 128'(1));
            if (wr0) begin
                chk("wa0", 128'(wa0), 128'(mq[0].lreg));
                chk("i0", i0, mq[0].dat);
            end
            if (wr1) begin
                chk("wa1", 128'(wa1), 128'(mq[1].lreg));
                chk("i1", i1, mq[1].dat);
            end
        end
        @(posedge clk);
        for (int k = 0; k < ndeq; k++) void'(mq.pop_front());
        if (rdy && v0) begin
            if (r0 != 3'd0) mq.push_back(lk_wr_t'{lreg: r0, dat: d0});
            if (v1 && r1 != 3'd0) mq.push_back(lk_wr_t'{lreg: r1, dat: d1});
        end
        #1;
    endtask

    task automatic idle(input logic h);
        cyc(1'b0, 3'd0, 128'd0, 1'b0, 3'd0, 128'd0, h);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid0 = 1'b0; in_reg0 = '0; in_dat0 = '0;
        in_valid1 = 1'b0; in_reg1 = '0; in_dat1 = '0;
        hold = 1'b0;
        #12;
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_empty", 128'(empty), 128'(1));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_wr0", 128'(wr0), 128'(0));
        chk("rst_wr1", 128'(wr1), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b0);

        // single entry
        cyc(1'b1, 3'd3, rnd(), 1'b0, 3'd6, rnd(), 1'b0);
        idle(1'b0);
        idle(1'b0);

        // same-register pair coalesces
        cyc(1'b1, 3'd5, rnd(), 1'b1, 3'd5, rnd(), 1'b0);
        idle(1'b0);
        idle(1'b0);

        // register 0 filtered
        cyc(1'b1, 3'd0, rnd(), 1'b1, 3'd2, rnd(), 1'b0);
        idle(1'b0);
        idle(1'b0);

        // slot 1 ignored without slot 0
        cyc(1'b0, 3'd4, rnd(), 1'b1, 3'd4, rnd(), 1'b0);
        idle(1'b0);

        // fill to full under hold, offer a rejected pair, then drain across wrap
        for (int k = 0; k < 4; k++)
            cyc(1'b1, 3'(2 * k + 1), rnd(), 1'b1, 3'((2 * k + 1) % 7 + 1), rnd(), 1'b1);
        cyc(1'b1, 3'd6, rnd(), 1'b1, 3'd7, rnd(), 1'b1);
        for (int k = 0; k < 5; k++) idle(1'b0);

        // count 7 blocks acceptance
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 3'(k + 1), rnd(), 1'b1, 3'(k + 4), rnd(), 1'b1);
        cyc(1'b1, 3'd7, rnd(), 1'b0, 3'd0, rnd(), 1'b1);
        cyc(1'b1, 3'd2, rnd(), 1'b1, 3'd3, rnd(), 1'b1);
        for (int k = 0; k < 5; k++) idle(1'b0);

        // simultaneous enqueue and dequeue at count 2
        cyc(1'b1, 3'd4, rnd(), 1'b1, 3'd6, rnd(), 1'b1);
        cyc(1'b1, 3'd1, rnd(), 1'b1, 3'd7, rnd(), 1'b0);
        cyc(1'b1, 3'd3, rnd(), 1'b1, 3'd3, rnd(), 1'b0);
        for (int k = 0; k < 3; k++) idle(1'b0);

        // mid-operation reset at count 5
        cyc(1'b1, 3'd1, rnd(), 1'b1, 3'd2, rnd(), 1'b1);
        cyc(1'b1, 3'd3, rnd(), 1'b1, 3'd4, rnd(), 1'b1);
        cyc(1'b1, 3'd5, rnd(), 1'b0, 3'd0, rnd(), 1'b1);
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        hold = 1'b0;
        #2;
        chk("pre_rst_count", 128'(count), 128'(5));
        chk("pre_rst_wr1", 128'(wr1), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr0", 128'(wr0), 128'(0));
        chk("mid_rst_wr1", 128'(wr1), 128'(0));
        chk("mid_rst_count", 128'(count), 128'(0));
        chk("mid_rst_empty", 128'(empty), 128'(1));
        chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b0);
        idle(1'b0);
        cyc(1'b1, 3'd6, rnd(), 1'b0, 3'd0, rnd(), 1'b0);
        idle(1'b0);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
